// File: rtl/mem_bus_controller.sv
// mem_bus_controller
// Arbitrates instruction fetches and data reads/writes onto a single external
// memory port using a four-phase request/ready handshake with wait-state
// timeout. Every output is driven directly from a register.
module mem_bus_controller #(
   parameter int DATA_W        = 32,
   parameter int ADDR_W        = 32,
   parameter int TIMEOUT       = 15,
   parameter int PRIORITY_MODE = 2
) (
   input  logic              clk,
   input  logic              rst,
   // Fetch side
   input  logic [ADDR_W-1:0] PCAddressBus,
   input  logic              PCGetNewInstruction,
   output logic [DATA_W-1:0] InstructionBus,
   output logic              InstructionValid,
   // Data side
   input  logic [ADDR_W-1:0] ALUAddressBus,
   input  logic [1:0]        MemoryIOBus,
   input  logic [DATA_W-1:0] InternalDataIn,
   output logic [DATA_W-1:0] InternalDataOut,
   output logic              ValidMemoryData,
   output logic              MemoryError,
   // External memory port
   output logic [ADDR_W-1:0] ExternalAddressBus,
   output logic [DATA_W-1:0] ExternalDataOut,
   input  logic [DATA_W-1:0] ExternalDataIn,
   output logic              ExternalDataOE,
   output logic [2:0]        ExternalDrive,
   input  logic              ExternalExchangeReady
);

   localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   // The counter starts at 0 on entry, so the last allowed cycle is TIMEOUT-1.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   localparam logic [1:0] IO_READ  = 2'b01;
   localparam logic [1:0] IO_WRITE = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_WAIT,
      S_RELEASE
   } state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              fetch_next_q;   // alternate mode: 1 = fetch wins next contention
   logic              is_fetch_q;
   logic              is_write_q;

   logic [DATA_W-1:0] instr_q;
   logic              instr_valid_q;
   logic [DATA_W-1:0] rdata_q;
   logic              data_valid_q;
   logic              error_q;
   logic [ADDR_W-1:0] ext_addr_q;
   logic [DATA_W-1:0] ext_wdata_q;
   logic              ext_oe_q;
   logic [2:0]        ext_drive_q;

   logic fetch_req;
   logic data_req;
   logic grant_any_d;
   logic grant_fetch_d;
   logic grant_write_d;

   // Reserved code 11 is not a data request.
   assign fetch_req   = PCGetNewInstruction;
   assign data_req    = (MemoryIOBus == IO_READ) || (MemoryIOBus == IO_WRITE);
   assign grant_any_d = fetch_req || data_req;

   // Grant decision for the current IDLE cycle.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave it holding its old value and infer a latch.
      grant_fetch_d = 1'b0;
      grant_write_d = 1'b0;
      if (fetch_req && data_req) begin
         case (PRIORITY_MODE)
            0:       grant_fetch_d = 1'b0;
            1:       grant_fetch_d = 1'b1;
            default: grant_fetch_d = fetch_next_q;
         endcase
      end else begin
         grant_fetch_d = fetch_req;
      end
      grant_write_d = !grant_fetch_d && (MemoryIOBus == IO_WRITE);
   end

   // Handshake FSM with registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         fetch_next_q  <= 1'b0;
         is_fetch_q    <= 1'b0;
         is_write_q    <= 1'b0;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
         rdata_q       <= '0;
         data_valid_q  <= 1'b0;
         error_q       <= 1'b0;
         ext_addr_q    <= '0;
         ext_wdata_q   <= '0;
         ext_oe_q      <= 1'b0;
         ext_drive_q   <= 3'b000;
      end else begin
         // Status outputs are single-cycle pulses.
         instr_valid_q <= 1'b0;
         data_valid_q  <= 1'b0;
         error_q       <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (grant_any_d) begin
                  state_q      <= S_SETUP;
                  is_fetch_q   <= grant_fetch_d;
                  is_write_q   <= grant_write_d;
                  fetch_next_q <= !grant_fetch_d;
                  ext_addr_q   <= grant_fetch_d ? PCAddressBus : ALUAddressBus;
                  if (grant_write_d) begin
                     ext_wdata_q <= InternalDataIn;
                  end
                  ext_oe_q     <= grant_write_d;
                  ext_drive_q  <= {grant_fetch_d, grant_write_d, 1'b1};
               end
            end

            S_SETUP: begin
               // Address phase; ready is not looked at yet.
               state_q <= S_WAIT;
               cnt_q   <= '0;
            end

            S_WAIT: begin
               if (ExternalExchangeReady) begin
                  if (is_fetch_q) begin
                     instr_q       <= ExternalDataIn;
                     instr_valid_q <= 1'b1;
                  end else begin
                     if (!is_write_q) begin
                        rdata_q <= ExternalDataIn;
                     end
                     data_valid_q <= 1'b1;
                  end
                  state_q     <= S_RELEASE;
                  cnt_q       <= '0;
                  ext_oe_q    <= 1'b0;
                  ext_drive_q <= 3'b000;
               end else if (cnt_q == CNT_LAST) begin
                  error_q     <= 1'b1;
                  state_q     <= S_RELEASE;
                  cnt_q       <= '0;
                  ext_oe_q    <= 1'b0;
                  ext_drive_q <= 3'b000;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            S_RELEASE: begin
               // Wait for the memory to drop its acknowledge.
               if (!ExternalExchangeReady) begin
                  state_q <= S_IDLE;
               end else if (cnt_q == CNT_LAST) begin
                  error_q <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign InstructionBus     = instr_q;
   assign InstructionValid   = instr_valid_q;
   assign InternalDataOut    = rdata_q;
   assign ValidMemoryData    = data_valid_q;
   assign MemoryError        = error_q;
   assign ExternalAddressBus = ext_addr_q;
   assign ExternalDataOut    = ext_wdata_q;
   assign ExternalDataOE     = ext_oe_q;
   assign ExternalDrive      = ext_drive_q;

endmodule

// File: doc/mem_bus_controller.md
# mem_bus_controller

Parametrised external-memory bus controller between the CPU core and the single external memory port. Arbitrates instruction fetches (PC side) and data reads/writes (ALU side) under a selectable priority mode, runs a four-phase request/ready handshake with a wait-state timeout, and returns fetched words and data to the requesters. Replaces the fixed 32-bit, fetch-only-or-data-only controller: adds arbitration, timeout error reporting and split data buses.

## Interface
- DATA_W, 32: data bus width.
- ADDR_W, 32: address bus width.
- TIMEOUT, 15: maximum wait cycles for ExternalExchangeReady in WAIT and for its release in RELEASE; legal range ≥1.
- PRIORITY_MODE, 2: 0 = data always wins, 1 = fetch always wins, 2 = alternate (last granted loses).
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- PCAddressBus  in  ADDR_W  fetch address.
- PCGetNewInstruction  in  1  fetch request, level.
- InstructionBus  out  DATA_W  last fetched word.
- InstructionValid  out  1  one-cycle pulse: InstructionBus updated.
- ALUAddressBus  in  ADDR_W  data address.
- MemoryIOBus  in  2  00 idle, 01 read, 10 write, 11 reserved (treated as idle).
- InternalDataIn  in  DATA_W  write data.
- InternalDataOut  out  DATA_W  last read data word.
- ValidMemoryData  out  1  one-cycle pulse: data read or write completed.
- MemoryError  out  1  one-cycle pulse: timeout.
- ExternalAddressBus  out  ADDR_W  memory address.
- ExternalDataOut  out  DATA_W  memory write data.
- ExternalDataIn  in  DATA_W  memory read data.
- ExternalDataOE  out  1  high while driving ExternalDataOut (write).
- ExternalDrive  out  3  [0] request, [1] write (1) / read (0), [2] instruction-space access.
- ExternalExchangeReady  in  1  memory ready / acknowledge.

## Operation
- States: IDLE, SETUP, WAIT, RELEASE. All outputs registered.
- IDLE: a fetch request (PCGetNewInstruction=1) and/or data request (MemoryIOBus=01/10) is sampled. One pending → grant it. Both pending → grant per PRIORITY_MODE; in mode 2 the requester not granted last wins; the pointer resets to "data next". On grant: latch address, write data, kind; → SETUP.
- SETUP (1 cycle): ExternalAddressBus, ExternalDrive = {fetch, write, 1}; ExternalDataOE=1 and ExternalDataOut valid for writes. Ready ignored. → WAIT.
- WAIT: outputs held; counter increments each edge without ready. Ready sampled high → capture ExternalDataIn (fetch → InstructionBus + InstructionValid; read → InternalDataOut + ValidMemoryData; write → ValidMemoryData only), → RELEASE. Counter reaches TIMEOUT → MemoryError pulse, no valid pulse, captured registers unchanged, → RELEASE.
- RELEASE: ExternalDrive=0, ExternalDataOE=0, address held. → IDLE on the first edge with ExternalExchangeReady low. Ready still high after TIMEOUT cycles → MemoryError pulse, forced → IDLE.
- Requester inputs are ignored from grant until IDLE. A requester drops its request in the cycle its valid pulse is high; any request sampled in IDLE is a new transaction.
- Counter width $clog2(TIMEOUT+1), cleared on entry to WAIT and to RELEASE.

## Timing
- Reset (async assert, sync release): state IDLE, all outputs 0, counter 0, round-robin pointer = data.
- Request high before edge 0 (IDLE) → SETUP after edge 0; WAIT after edge 1; ready is sampled from edge 2 on.
- Ready high before edge k (k≥2) → valid pulse and data visible after edge k. Minimum request-to-valid: 3 edges. Minimum back-to-back spacing: 4 edges (RELEASE ≥1 cycle, IDLE 1 cycle).
- Timeout: with ready never high, MemoryError pulses after edge 1+TIMEOUT.
- Reset mid-transaction: ExternalDrive and OE drop immediately; the transaction is lost with no valid or error pulse.
- MemoryIOBus=11 with a fetch pending: the fetch is granted and 11 is ignored.

## Test plan
- Fetch: PCAddressBus=540, PCGetNewInstruction=1, ready with ExternalDataIn=339 on the 3rd wait cycle → ExternalDrive=101 during access, InstructionBus=339, one InstructionValid pulse, 5 edges after request.
- Data read: ALUAddressBus=4467, MemoryIOBus=01, ExternalDataIn=555 → ExternalAddressBus=4467, ExternalDrive=001, InternalDataOut=555, one ValidMemoryData pulse, InstructionBus unchanged.
- Write: ALUAddressBus=4467, MemoryIOBus=10, InternalDataIn=555 → ExternalDataOE=1, ExternalDataOut=555, ExternalDrive=011 from SETUP through ready; ValidMemoryData pulse; OE low in RELEASE.
- Contention, PRIORITY_MODE=2: fetch and read held continuously → grants alternate data, fetch, data, fetch; modes 0 and 1 always grant data or fetch respectively.
- Timeout, TIMEOUT=4: read with ready held low → MemoryError pulse after edge 5, no ValidMemoryData, InternalDataOut keeps its old value, returns to IDLE; ready stuck high in RELEASE → second MemoryError after 4 cycles.
- Reset mid-WAIT: assert rst between edges → all outputs 0 at once; after release a new fetch completes normally.
